// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction and data streams.
// Data wins arbitration unless instructions have waited MAX_DSTREAK grants.
module mem_arbiter #(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SMAX  = SW'(MAX_DSTREAK);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [SW-1:0] dstreak;
  logic [TW-1:0] tcnt;

  logic dreq;
  logic ifav;
  logic own;
  logic access;

  assign dreq   = dREN | dWEN;
  assign ifav   = iREN && (dstreak == SMAX);
  assign own    = (state == GNT_I) ? iREN : dreq;
  assign access = (ramstate == RS_ACCESS);
  assign iload  = ramload;
  assign dload  = ramload;

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~(iREN & access);
      end
      GNT_D: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~(dreq & access);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
      tcnt    <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (dreq && !ifav)
            state <= GNT_D;
          else if (iREN)
            state <= GNT_I;
        end
        default: begin
          if (!own) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (access) begin
            state <= IDLE;
            tcnt  <= '0;
            if (state == GNT_I || !iREN)
              dstreak <= '0;
            else if (dstreak != SMAX)
              dstreak <= dstreak + 1'b1;
          end else if (ramstate == RS_ERROR || tcnt >= TLAST) begin
            // abort: this cycle is the last one allowed without ACCESS
            err   <= 1'b1;
            state <= IDLE;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, fairness,
// timeout, RAM error, withdrawal and reset.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  mem_arbiter #(
    .WORD_W(32),
    .MAX_DSTREAK(4),
    .TIMEOUT(15)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .dwait(dwait),
    .dload(dload),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ramload(ramload),
    .ramstate(ramstate),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  logic [31:0] exp3 [6];

  initial begin
    exp3 = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h40, 32'h200};
    nRST = 1'b0; iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = 32'h2408000A; ramstate = FREE;

    nxt(); nxt(); #1;
    chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iwait", {31'b0, iwait}, 32'd1);
    chk("rst_dwait", {31'b0, dwait}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);

    // 1: instruction fetch, ACCESS one cycle after grant
    nxt(); nRST = 1'b1; iREN = 1'b1; iaddr = 32'h40; #1;
    chk("t1_idle_ramREN", {31'b0, ramREN}, 32'd0);
    nxt(); ramstate = BUSY; #1;
    chk("t1_gnt_ramREN", {31'b0, ramREN}, 32'd1);
    chk("t1_gnt_ramaddr", ramaddr, 32'h40);
    chk("t1_busy_iwait", {31'b0, iwait}, 32'd1);
    nxt(); ramstate = ACCESS; #1;
    chk("t1_acc_iwait", {31'b0, iwait}, 32'd0);
    chk("t1_acc_iload", iload, 32'h2408000A);
    chk("t1_acc_dwait", {31'b0, dwait}, 32'd1);
    nxt(); iREN = 1'b0; ramstate = FREE; #1;
    chk("t1_idle_after", {31'b0, ramREN}, 32'd0);

    // 2: simultaneous iREN and dWEN, data first
    nxt(); iREN = 1'b1; dWEN = 1'b1;
    daddr = 32'h100; dstore = 32'hDEADBEEF; #1;
    chk("t2_idle_ramWEN", {31'b0, ramWEN}, 32'd0);
    nxt(); ramstate = ACCESS; #1;
    chk("t2_d_ramWEN", {31'b0, ramWEN}, 32'd1);
    chk("t2_d_ramREN", {31'b0, ramREN}, 32'd0);
    chk("t2_d_ramaddr", ramaddr, 32'h100);
    chk("t2_d_ramstore", ramstore, 32'hDEADBEEF);
    chk("t2_d_dwait", {31'b0, dwait}, 32'd0);
    chk("t2_d_iwait", {31'b0, iwait}, 32'd1);
    nxt(); dWEN = 1'b0; ramstate = FREE; #1;
    chk("t2_idle2", {31'b0, ramREN}, 32'd0);
    nxt(); ramstate = ACCESS; #1;
    chk("t2_i_ramREN", {31'b0, ramREN}, 32'd1);
    chk("t2_i_ramaddr", ramaddr, 32'h40);
    chk("t2_i_ramstore", ramstore, 32'd0);
    chk("t2_i_iwait", {31'b0, iwait}, 32'd0);
    chk("t2_i_dwait", {31'b0, dwait}, 32'd1);

    // 3: starvation guard, grants D,D,D,D,I,D
    nxt(); iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_idle%0d", k), {31'b0, ramREN}, 32'd0);
      nxt(); #1;
      chk($sformatf("t3_gnt%0d_addr", k), ramaddr, exp3[k]);
      nxt(); #1;
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;

    // 4: timeout after 15 BUSY cycles
    nxt(); dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; #1;
    for (int c = 1; c <= 15; c++) begin
      nxt(); #1;
      chk($sformatf("t4_c%0d_ramREN", c), {31'b0, ramREN}, 32'd1);
      chk($sformatf("t4_c%0d_dwait", c), {31'b0, dwait}, 32'd1);
      chk($sformatf("t4_c%0d_err", c), {31'b0, err}, 32'd0);
    end
    nxt(); #1;
    chk("t4_abort_err", {31'b0, err}, 32'd1);
    chk("t4_abort_idle", {31'b0, ramREN}, 32'd0);
    chk("t4_abort_dwait", {31'b0, dwait}, 32'd1);
    nxt(); #1;
    chk("t4_rearb", {31'b0, ramREN}, 32'd1);
    nxt(); dREN = 1'b0; #1;
    chk("t4_withdraw", {31'b0, ramREN}, 32'd0);
    nxt(); ramstate = FREE; #1;
    chk("t4_err_sticky", {31'b0, err}, 32'd1);

    // 5: RAM ERROR during GNT_I, then reset
    nRST = 1'b0;
    nxt(); nRST = 1'b1; #1;
    chk("t5_rst_err", {31'b0, err}, 32'd0);
    iREN = 1'b1; iaddr = 32'h44;
    nxt(); ramstate = ERROR; #1;
    chk("t5_gnt_ramaddr", ramaddr, 32'h44);
    chk("t5_err_iwait", {31'b0, iwait}, 32'd1);
    chk("t5_err_pre", {31'b0, err}, 32'd0);
    nxt(); ramstate = FREE; #1;
    chk("t5_err_set", {31'b0, err}, 32'd1);
    chk("t5_idle", {31'b0, ramREN}, 32'd0);
    nRST = 1'b0;
    nxt(); #1;
    chk("t5_rst_err2", {31'b0, err}, 32'd0);
    chk("t5_rst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("t5_rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    nRST = 1'b1;
    nxt(); #1;
    chk("t5_gnt2", {31'b0, ramREN}, 32'd1);
    nRST = 1'b0;
    nxt(); #1;
    chk("t5_rst_midgnt", {31'b0, ramREN}, 32'd0);
    nRST = 1'b1; iREN = 1'b0;

    // 6: data withdrawal on second BUSY cycle
    nxt(); dREN = 1'b1; daddr = 32'h500; ramstate = BUSY; #1;
    chk("t6_idle", {31'b0, ramREN}, 32'd0);
    nxt(); #1;
    chk("t6_busy1", {31'b0, ramREN}, 32'd1);
    nxt(); dREN = 1'b0; #1;
    chk("t6_drop_ramREN", {31'b0, ramREN}, 32'd0);
    chk("t6_drop_dwait", {31'b0, dwait}, 32'd1);
    nxt(); dREN = 1'b1; #1;
    chk("t6_back_idle", {31'b0, ramREN}, 32'd0);
    chk("t6_err", {31'b0, err}, 32'd0);
    nxt(); dREN = 1'b0; ramstate = FREE;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
